// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bus bundle between the CPU datapath requesters, the
// arbiter and the single-ported RAM model.
// Optional macro ARB_STATS_EN adds the igrants/dgrants/stall_cycles counters.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  // data (LW/SW) side
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  // status
  logic              memerr;
`ifdef ARB_STATS_EN
  logic [31:0]       igrants;
  logic [31:0]       dgrants;
  logic [31:0]       stall_cycles;
`endif

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef ARB_STATS_EN
    , output igrants, dgrants, stall_cycles
`endif
  );

  // requester / RAM environment view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef ARB_STATS_EN
    , input igrants, dgrants, stall_cycles
`endif
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and
// data (LW/SW) requests. Data wins by default; after STARVE_LIMIT consecutive
// data completions with fetch pending, fetch is forced next. A grant that stays
// un-ACCESSed for TIMEOUT cycles raises the sticky memerr flag.
// Optional macro ARB_STATS_EN adds completion and stall counters.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRD    = 2'b01,
    DWR    = 2'b10,
    IFETCH = 2'b11
  } state_t;

  state_t              state_r;
  logic                ram_ren_r;
  logic                ram_wen_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_store_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                memerr_r;
  logic [STARVE_W-1:0] starve_cnt_r;

  logic access_s;
  logic d_req_s;
  logic d_own_s;
  logic i_own_s;
  logic d_drop_s;
  logic i_drop_s;
  logic d_done_s;
  logic i_done_s;
  logic iwait_s;
  logic dwait_s;
  logic starved_s;

  // Owner/completion decode and the combinational wait handshakes.
  always_comb begin
    access_s  = (bus.ramstate == RAM_ACCESS);
    d_req_s   = bus.dREN | bus.dWEN;
    d_own_s   = (state_r == DRD) || (state_r == DWR);
    i_own_s   = (state_r == IFETCH);
    // a dropped request abandons the grant even if the RAM answers that cycle
    if (state_r == DRD) begin
      d_drop_s = !bus.dREN;
    end else if (state_r == DWR) begin
      d_drop_s = !bus.dWEN;
    end else begin
      d_drop_s = 1'b0;
    end
    i_drop_s  = i_own_s && !bus.iREN;
    d_done_s  = d_own_s && !d_drop_s && access_s;
    i_done_s  = i_own_s && !i_drop_s && access_s;
    iwait_s   = bus.iREN && !i_done_s;
    dwait_s   = d_req_s && !d_done_s;
    starved_s = (starve_cnt_r == STARVE_W'(STARVE_LIMIT));
  end

  // Grant FSM with registered RAM drive, grant timeout and sticky error flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r     <= IDLE;
      ram_ren_r   <= 1'b0;
      ram_wen_r   <= 1'b0;
      ram_addr_r  <= '0;
      ram_store_r <= '0;
      tmo_cnt_r   <= '0;
      memerr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tmo_cnt_r <= '0;
          if (starved_s && bus.iREN) begin
            state_r    <= IFETCH;
            ram_ren_r  <= 1'b1;
            ram_wen_r  <= 1'b0;
            ram_addr_r <= bus.iaddr;
          end else if (bus.dWEN) begin
            state_r     <= DWR;
            ram_ren_r   <= 1'b0;
            ram_wen_r   <= 1'b1;
            ram_addr_r  <= bus.daddr;
            ram_store_r <= bus.dstore;
          end else if (bus.dREN) begin
            state_r    <= DRD;
            ram_ren_r  <= 1'b1;
            ram_wen_r  <= 1'b0;
            ram_addr_r <= bus.daddr;
          end else if (bus.iREN) begin
            state_r    <= IFETCH;
            ram_ren_r  <= 1'b1;
            ram_wen_r  <= 1'b0;
            ram_addr_r <= bus.iaddr;
          end else begin
            ram_ren_r <= 1'b0;
            ram_wen_r <= 1'b0;
          end
        end
        DRD, DWR, IFETCH: begin
          if (d_drop_s || i_drop_s || d_done_s || i_done_s) begin
            // one bubble cycle in IDLE before the next grant
            state_r   <= IDLE;
            ram_ren_r <= 1'b0;
            ram_wen_r <= 1'b0;
            tmo_cnt_r <= '0;
          end else begin
            // FREE/BUSY/ERROR: keep presenting the same request
            if (tmo_cnt_r != TMO_W'(TIMEOUT)) begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
              memerr_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          ram_ren_r <= 1'b0;
          ram_wen_r <= 1'b0;
          tmo_cnt_r <= '0;
        end
      endcase
    end
  end

  // Starvation guard: consecutive data completions while fetch is waiting.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve_cnt_r <= '0;
    end else if (!bus.iREN || i_done_s) begin
      starve_cnt_r <= '0;
    end else if (d_done_s && !starved_s) begin
      starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] igrants_r;
  logic [31:0] dgrants_r;
  logic [31:0] stall_cycles_r;

  // Completion and stall statistics, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrants_r      <= 32'd0;
      dgrants_r      <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      if (i_done_s) begin
        igrants_r <= igrants_r + 32'd1;
      end
      if (d_done_s) begin
        dgrants_r <= dgrants_r + 32'd1;
      end
      if ((bus.iREN || d_req_s) && (iwait_s || dwait_s)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
    end
  end

  assign bus.igrants      = igrants_r;
  assign bus.dgrants      = dgrants_r;
  assign bus.stall_cycles = stall_cycles_r;
`endif

  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = ram_ren_r;
  assign bus.ramWEN   = ram_wen_r;
  assign bus.ramaddr  = ram_addr_r;
  assign bus.ramstore = ram_store_r;
  assign bus.memerr   = memerr_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a completion scoreboard.
// Stimulus pushes each expected completion into exp_q; the monitor pops and
// compares whenever the DUT drops iwait/dwait on an active request.
// Build with ARB_STATS_EN defined to also check the statistics counters.
module tb_memory_arbiter;

  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic CLK;
  logic nRST;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct {
    bit          is_data;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_data, input bit wen, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_t e;
    e.is_data = is_data;
    e.wen     = wen;
    e.addr    = addr;
    e.data    = data;
    exp_q.push_back(e);
  endtask

  task automatic check_completion(input bit is_data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_completion: got is_data=%0d expected none at %0t", is_data, $time);
    end else begin
      e = exp_q.pop_front();
      check1("cmp_kind", is_data, e.is_data);
      check("cmp_ramaddr", bus.ramaddr, e.addr);
      if (e.wen) begin
        check1("cmp_ramwen", bus.ramWEN, 1'b1);
        check("cmp_ramstore", bus.ramstore, e.data);
      end else begin
        check1("cmp_ramren", bus.ramREN, 1'b1);
        check("cmp_load", is_data ? bus.dload : bus.iload, e.data);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic set_ram(input logic [1:0] st, input logic [31:0] ld);
    bus.ramstate = st;
    bus.ramload  = ld;
  endtask

  // monitor: a completion is any active request whose wait is low
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (bus.iREN && !bus.iwait) check_completion(1'b0);
        if ((bus.dREN || bus.dWEN) && !bus.dwait) check_completion(1'b1);
      end
    end
  end

  // watchdog so the run always ends
  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got no end of test expected finish within 20000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    nRST       = 1'b0;
    bus.iREN   = 1'b0;
    bus.iaddr  = 32'h0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = 32'h0;
    bus.dstore = 32'h0;
    set_ram(RS_FREE, 32'h0);
    repeat (2) @(posedge CLK);
    #1;

    // ---- reset state
    sample();
    check1("rst_ramren", bus.ramREN, 1'b0);
    check1("rst_ramwen", bus.ramWEN, 1'b0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    check1("rst_memerr", bus.memerr, 1'b0);
    check1("rst_iwait_idle", bus.iwait, 1'b0);
    next_cycle();
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    sample();
    check1("rst_iwait_req", bus.iwait, 1'b1);
    check1("rst_dwait_req", bus.dwait, 1'b1);
    next_cycle();
    check1("rst_ramren_req", bus.ramREN, 1'b0);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    nRST     = 1'b1;

    // ---- T1: fetch only
    next_cycle();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    set_ram(RS_FREE, 32'h0);
    push_exp(1'b0, 1'b0, 32'h40, 32'h3C010001);
    sample();
    check1("t1_iwait_n", bus.iwait, 1'b1);
    check1("t1_ramren_n", bus.ramREN, 1'b0);
    next_cycle();
    sample();
    check1("t1_ramren_n1", bus.ramREN, 1'b1);
    check("t1_ramaddr_n1", bus.ramaddr, 32'h40);
    check1("t1_iwait_n1", bus.iwait, 1'b1);
    next_cycle();
    set_ram(RS_ACCESS, 32'h3C010001);
    sample();
    check1("t1_iwait_n2", bus.iwait, 1'b0);
    check("t1_iload_n2", bus.iload, 32'h3C010001);
    next_cycle();
    bus.iREN = 1'b0;
    set_ram(RS_FREE, 32'h0);
    sample();
    check1("t1_ramren_n3", bus.ramREN, 1'b0);

    // ---- T2: simultaneous fetch and store, store wins
    next_cycle();
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h44;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'hDEAD;
    push_exp(1'b1, 1'b1, 32'h80, 32'hDEAD);
    push_exp(1'b0, 1'b0, 32'h44, 32'h11112222);
    next_cycle();
    set_ram(RS_ACCESS, 32'h0);
    sample();
    check1("t2_ramwen", bus.ramWEN, 1'b1);
    check1("t2_ramren", bus.ramREN, 1'b0);
    check("t2_ramstore", bus.ramstore, 32'hDEAD);
    check("t2_ramaddr", bus.ramaddr, 32'h80);
    check1("t2_iwait", bus.iwait, 1'b1);
    next_cycle();
    bus.dWEN = 1'b0;
    set_ram(RS_FREE, 32'h0);
    sample();
    check1("t2_bubble_ren", bus.ramREN, 1'b0);
    check1("t2_bubble_wen", bus.ramWEN, 1'b0);
    next_cycle();
    set_ram(RS_ACCESS, 32'h11112222);
    sample();
    check1("t2_fetch_ren", bus.ramREN, 1'b1);
    check("t2_fetch_addr", bus.ramaddr, 32'h44);
    next_cycle();
    bus.iREN = 1'b0;
    set_ram(RS_FREE, 32'h0);

    // ---- T3: starvation guard, limit 4
    next_cycle();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h100;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    set_ram(RS_ACCESS, 32'h0BADBEEF);
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 32'h200, 32'h0BADBEEF);
    push_exp(1'b0, 1'b0, 32'h100, 32'h0BADBEEF);
    push_exp(1'b1, 1'b0, 32'h200, 32'h0BADBEEF);
    for (int c = 0; c < 12; c++) begin
      sample();
      if (c == 7) check("t3_4th_data_addr", bus.ramaddr, 32'h200);
      if (c == 9) begin
        check("t3_forced_fetch_addr", bus.ramaddr, 32'h100);
        check1("t3_dwait_during_fetch", bus.dwait, 1'b1);
      end
      if (c == 11) check("t3_data_resumes", bus.ramaddr, 32'h200);
      next_cycle();
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    set_ram(RS_FREE, 32'h0);

    // ---- T4: ERROR retried three cycles, then ACCESS
    next_cycle();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    set_ram(RS_ERROR, 32'h0);
    push_exp(1'b1, 1'b0, 32'h300, 32'h12345678);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      set_ram(RS_ERROR, 32'h0);
      sample();
      check("t4_hold_addr", bus.ramaddr, 32'h300);
      check1("t4_hold_ren", bus.ramREN, 1'b1);
      check1("t4_dwait", bus.dwait, 1'b1);
    end
    next_cycle();
    set_ram(RS_ACCESS, 32'h12345678);
    sample();
    next_cycle();
    bus.dREN = 1'b0;
    set_ram(RS_FREE, 32'h0);
    sample();
    check1("t4_idle_ren", bus.ramREN, 1'b0);
`ifdef ARB_STATS_EN
    check("t4_igrants", bus.igrants, 32'd3);
    check("t4_dgrants", bus.dgrants, 32'd7);
`endif

    // ---- T5: stuck BUSY, timeout 8, then reset
    check1("t5_memerr_pre", bus.memerr, 1'b0);
    next_cycle();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h500;
    set_ram(RS_BUSY, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      sample();
      if (c == 8) check1("t5_memerr_c8", bus.memerr, 1'b0);
      if (c == 9) check1("t5_memerr_c9", bus.memerr, 1'b1);
      if (c == 12) begin
        check1("t5_memerr_sticky", bus.memerr, 1'b1);
        check1("t5_still_granted", bus.ramREN, 1'b1);
        check("t5_addr_held", bus.ramaddr, 32'h500);
      end
    end
    next_cycle();
    nRST = 1'b0;
    sample();
    check1("t5_memerr_before_rst", bus.memerr, 1'b1);
    next_cycle();
    nRST     = 1'b1;
    bus.iREN = 1'b0;
    set_ram(RS_FREE, 32'h0);
    sample();
    check1("t5_memerr_after_rst", bus.memerr, 1'b0);
    check1("t5_ramren_after_rst", bus.ramREN, 1'b0);
    check("t5_ramaddr_after_rst", bus.ramaddr, 32'h0);

    // ---- T6: data request dropped after one BUSY cycle
    next_cycle();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h600;
    set_ram(RS_BUSY, 32'h0);
    next_cycle();
    sample();
    check1("t6_dwait", bus.dwait, 1'b1);
    check1("t6_ramren", bus.ramREN, 1'b1);
    next_cycle();
    bus.dREN = 1'b0;
    set_ram(RS_ACCESS, 32'h77777777);
    sample();
    check1("t6_ramren_drop_cycle", bus.ramREN, 1'b1);
    next_cycle();
    set_ram(RS_FREE, 32'h0);
    sample();
    check1("t6_idle_ren", bus.ramREN, 1'b0);
`ifdef ARB_STATS_EN
    check("t6_dgrants", bus.dgrants, 32'd0);
    check("t6_igrants", bus.igrants, 32'd0);
    check("t6_stall_cycles", bus.stall_cycles, 32'd2);
`endif

    repeat (2) next_cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
